// File: rtl/line_win3_buf_if.sv
// Pixel stream in, three-row window out, for the line window buffer.
interface line_win3_buf_if #(
    parameter int H_ACT = 1280,
    parameter int DW    = 24
);
    localparam int CW = $clog2(H_ACT + 1);

    logic          vsync_i;
    logic          de_i;
    logic [DW-1:0] data_i;
    logic          vsync_o;
    logic          de_o;
    logic [DW-1:0] row0_o;
    logic [DW-1:0] row1_o;
    logic [DW-1:0] row2_o;
    logic [CW-1:0] col_o;

    modport master (
        output vsync_i, de_i, data_i,
        input  vsync_o, de_o, row0_o, row1_o, row2_o, col_o
    );

    modport slave (
        input  vsync_i, de_i, data_i,
        output vsync_o, de_o, row0_o, row1_o, row2_o, col_o
    );
endinterface

// File: rtl/line_win3_buf.sv
// Three-row vertical window: current pixel plus same-column pixels of the two
// previous lines, held in two line RAMs; one-cycle latency, top rows zero-padded.
module line_win3_buf #(
    parameter int H_ACT = 1280,
    parameter int DW    = 24
) (
    input  logic           clk,
    input  logic           rstn,
    line_win3_buf_if.slave vif
);
    localparam int CW = $clog2(H_ACT + 1);
    localparam int AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;

    logic          de_d, vsync_d;
    logic [CW-1:0] col_reg, col_cur, col_next;
    logic [1:0]    lines_seen_reg, lines_seen_next;
    logic          pix_en;
    logic [AW-1:0] addr;

    logic          vsync_o_reg, de_o_reg;
    logic [DW-1:0] row0_reg;
    logic [CW-1:0] col_o_reg;
    logic          row1_ok_reg, row2_ok_reg;

    logic [DW-1:0] ram1 [H_ACT];
    logic [DW-1:0] ram2 [H_ACT];
    logic [DW-1:0] ram1_q, ram2_q;
    logic          wr2_en_reg;
    logic [AW-1:0] wr2_addr_reg;

    always_comb begin
        col_cur         = (vif.de_i && !de_d) ? '0 : col_reg;
        col_next        = col_reg;
        lines_seen_next = lines_seen_reg;
        if (vif.de_i)
            col_next = (col_cur == CW'(H_ACT)) ? col_cur : col_cur + CW'(1);
        if (vif.vsync_i && !vsync_d)
            lines_seen_next = 2'd0;
        else if (!vif.de_i && de_d && lines_seen_reg != 2'd2)
            lines_seen_next = lines_seen_reg + 2'd1;
        // RAM writes are not reset, so they must also be held off while rstn is low
        pix_en = rstn && vif.de_i && (col_cur < CW'(H_ACT));
        addr   = col_cur[AW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de_d           <= 1'b0;
            vsync_d        <= 1'b0;
            col_reg        <= '0;
            lines_seen_reg <= 2'd0;
            vsync_o_reg    <= 1'b0;
            de_o_reg       <= 1'b0;
            row0_reg       <= '0;
            col_o_reg      <= '0;
            row1_ok_reg    <= 1'b0;
            row2_ok_reg    <= 1'b0;
        end else begin
            de_d           <= vif.de_i;
            vsync_d        <= vif.vsync_i;
            col_reg        <= col_next;
            lines_seen_reg <= lines_seen_next;
            vsync_o_reg    <= vif.vsync_i;
            de_o_reg       <= vif.de_i;
            row0_reg       <= vif.de_i ? vif.data_i : '0;
            if (vif.de_i)
                col_o_reg <= col_cur;
            row1_ok_reg    <= pix_en && (lines_seen_reg >= 2'd1);
            row2_ok_reg    <= pix_en && (lines_seen_reg >= 2'd2);
        end
    end

    // ram2 is fed from ram1's read port one cycle later, so its write trails the read by a column
    always_ff @(posedge clk) begin
        if (pix_en) begin
            ram1_q     <= ram1[addr];
            ram2_q     <= ram2[addr];
            ram1[addr] <= vif.data_i;
        end
        if (wr2_en_reg)
            ram2[wr2_addr_reg] <= ram1_q;
        wr2_en_reg   <= pix_en;
        wr2_addr_reg <= addr;
    end

    assign vif.vsync_o = vsync_o_reg;
    assign vif.de_o    = de_o_reg;
    assign vif.row0_o  = row0_reg;
    assign vif.row1_o  = row1_ok_reg ? ram1_q : '0;
    assign vif.row2_o  = row2_ok_reg ? ram2_q : '0;
    assign vif.col_o   = col_o_reg;
endmodule

// File: tb/tb_line_win3_buf.sv
// Randomized and directed stimulus against a per-column history model with a queue scoreboard.
module tb_line_win3_buf;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int CW = $clog2(H + 1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    line_win3_buf_if #(.H_ACT(H), .DW(DW)) vif ();

    line_win3_buf #(.H_ACT(H), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .vif  (vif)
    );

    typedef struct {
        logic          vs;
        logic          de;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [CW-1:0] col;
        bit            k1;
        bit            k2;
    } exp_t;

    exp_t sb[$];

    // Model: last two values ever written at each column, plus frame/line bookkeeping.
    logic [DW-1:0] h1 [H];
    logic [DW-1:0] h2 [H];
    bit            k1 [H];
    bit            k2 [H];
    bit            m_de_d, m_vs_d;
    int            m_col, m_ls, m_colo;

    int  n_vec  = 0;
    int  n_fail = 0;
    bit  done   = 1'b0;

    task automatic cyc(input bit r, input bit v, input bit d, input logic [DW-1:0] x);
        exp_t e;
        int   c;
        @(negedge clk);
        rstn        = r;
        vif.vsync_i = v;
        vif.de_i    = d;
        vif.data_i  = x;
        if (!r) begin
            m_de_d = 0; m_vs_d = 0; m_col = 0; m_ls = 0; m_colo = 0;
        end else begin
            c    = (d && !m_de_d) ? 0 : m_col;
            e.vs = v;
            e.de = d;
            e.r0 = d ? x : '0;
            e.r1 = '0;
            e.r2 = '0;
            e.k1 = 1;
            e.k2 = 1;
            if (d) begin
                m_colo = c;
                if (c < H) begin
                    if (m_ls >= 1) begin e.r1 = h1[c]; e.k1 = k1[c]; end
                    if (m_ls >= 2) begin e.r2 = h2[c]; e.k2 = k2[c]; end
                    h2[c] = h1[c]; k2[c] = k1[c];
                    h1[c] = x;     k1[c] = 1;
                end
                m_col = (c < H) ? c + 1 : H;
            end
            e.col = CW'(m_colo);
            if (v && !m_vs_d)                   m_ls = 0;
            else if (!d && m_de_d && m_ls < 2) m_ls = m_ls + 1;
            m_de_d = d;
            m_vs_d = v;
            sb.push_back(e);
        end
    endtask

    task automatic line(input int base, input int len, input int gap);
        for (int i = 0; i < len; i++) cyc(1, 0, 1, DW'(base + i));
        for (int i = 0; i < gap; i++) cyc(1, 0, 0, '0);
    endtask

    task automatic vpulse();
        cyc(1, 1, 0, '0);
        cyc(1, 0, 0, '0);
    endtask

    // Monitor: every cycle, compare the DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        bit   ok;
        while (!done) begin
            @(posedge clk);
            #2;
            if (done) break;
            n_vec++;
            if (!rstn) begin
                ok = !vif.vsync_o && !vif.de_o && vif.row0_o == '0 && vif.row1_o == '0
                     && vif.row2_o == '0 && vif.col_o == '0;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL reset_outputs: got vs=%0b de=%0b r0=%0h r1=%0h r2=%0h col=%0d, need all 0",
                             vif.vsync_o, vif.de_o, vif.row0_o, vif.row1_o, vif.row2_o, vif.col_o);
                end
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got de=%0b with no expectation queued", vif.de_o);
            end else begin
                e  = sb.pop_front();
                ok = vif.vsync_o == e.vs && vif.de_o == e.de && vif.row0_o == e.r0
                     && (!e.k1 || vif.row1_o == e.r1) && (!e.k2 || vif.row2_o == e.r2)
                     && vif.col_o == e.col;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL pixel_out: got vs=%0b de=%0b r0=%0h r1=%0h r2=%0h col=%0d, need vs=%0b de=%0b r0=%0h r1=%0h r2=%0h col=%0d",
                             vif.vsync_o, vif.de_o, vif.row0_o, vif.row1_o, vif.row2_o, vif.col_o,
                             e.vs, e.de, e.r0, e.r1, e.r2, e.col);
                end
            end
            if (n_vec < 400 || !ok)
                $display("t=%0t rstn=%0b de_o=%0b col=%0d r0=%0h r1=%0h r2=%0h", $time, rstn,
                         vif.de_o, vif.col_o, vif.row0_o, vif.row1_o, vif.row2_o);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        int len, gap;
        for (int i = 0; i < H; i++) begin
            h1[i] = '0; h2[i] = '0; k1[i] = 0; k2[i] = 0;
        end
        m_de_d = 0; m_vs_d = 0; m_col = 0; m_ls = 0; m_colo = 0;
        rstn        = 1'b0;
        vif.vsync_i = 1'b0;
        vif.de_i    = 1'b0;
        vif.data_i  = '0;

        // Reset held with random inputs, then release into idle.
        for (int i = 0; i < 6; i++)
            cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);

        // Basic window: three lines of 16*line+col, blanking 4.
        vpulse();
        for (int l = 0; l < 3; l++) line(16 * l, H, 4);

        // Frame restart: new frame must not show the previous frame's lines.
        vpulse();
        line(8'h30, H, 4);

        // Overlong line followed by a normal line.
        line(8'h40, 10, 3);
        line(8'h60, H, 3);

        // Minimum blanking across four lines.
        vpulse();
        for (int l = 0; l < 4; l++) line(8'h80 + 16 * l, H, 1);

        // Reset in the middle of line 2, released while de is still high.
        vpulse();
        line(8'h00, H, 2);
        line(8'h10, H, 2);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, DW'(8'h20 + i));
        cyc(0, 0, 1, 8'h23);
        cyc(0, 0, 1, 8'h24);
        for (int i = 5; i < H; i++) cyc(1, 0, 1, DW'(8'h20 + i));
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        line(8'h30, H, 2);
        line(8'h40, H, 2);
        line(8'h50, H, 2);

        // Random lines, random vsync, rare resets.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) vpulse();
            len = $urandom_range(1, H + 2);
            gap = $urandom_range(1, 4);
            for (int i = 0; i < len; i++)
                cyc(($urandom_range(0, 80) != 0), ($urandom_range(0, 30) == 0), 1,
                    DW'($urandom_range(0, 255)));
            for (int i = 0; i < gap; i++)
                cyc(1, ($urandom_range(0, 5) == 0), 0, '0);
        end

        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        @(negedge clk);
        done = 1'b1;
        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d expectations left, need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/line_win3_buf.md
# line_win3_buf

Three-row vertical window buffer for the video pixel pipeline. It consumes the de-qualified pixel stream and generates its own per-line write column, restarted at every de rising edge. It stores the two most recent active lines in on-chip line RAMs and outputs, per pixel, the current pixel plus the same-column pixels from the previous two lines. Its output is the row feed for the 3x3 filter/detection stages downstream.

## Interface
- H_ACT, 1280, active pixels per line; RAM depth and column range.
- DW, 24, pixel data width (RGB888).
- clk  in  1  pixel clock.
- rstn  in  1  reset, asynchronous, active-low.
- vsync_i  in  1  frame sync; rising edge marks frame start.
- de_i  in  1  data enable; high during active pixels of a line.
- data_i  in  DW  pixel data, valid when de_i=1.
- vsync_o  out  1  vsync_i delayed 1 cycle.
- de_o  out  1  de_i delayed 1 cycle.
- row0_o  out  DW  current-line pixel (data_i delayed 1 cycle).
- row1_o  out  DW  same-column pixel from previous line, zero-padded.
- row2_o  out  DW  same-column pixel from two lines ago, zero-padded.
- col_o  out  $clog2(H_ACT+1)  column index of the pixel on row0_o.

## Operation
- Column counter col: width $clog2(H_ACT+1).
  - Set to 0 on the cycle de_i rises; de_d is reset to 0, so de_i high at reset release counts as a rise.
  - Increments on every de_i=1 cycle and saturates at H_ACT.
  - Holds while de_i=0.
- Two line RAMs, ram1 (previous line) and ram2 (two lines ago), each H_ACT x DW, simple dual-port, 1-cycle registered read. Contents are not reset.
- Per pixel with de_i=1 and col<H_ACT:
  - Read ram1[col] and ram2[col].
  - Write ram1[col] <= data_i in the same cycle (read-before-write).
  - One cycle later, write ram2[col] <= the value read from ram1[col].
- Pixels with col>=H_ACT (overlong line): not written. row1_o and row2_o are 0 for them, and row0_o passes through.
- Line counter lines_seen, 2 bits, saturating 0..2:
  - Increments on each de_i falling edge.
  - Cleared on vsync_i rising edge. When both happen in the same cycle, the clear wins.
- Zero padding (top border):
  - row1_o = 0 unless lines_seen>=1 at the pixel's input cycle.
  - row2_o = 0 unless lines_seen>=2 at the pixel's input cycle.
- When de_o=0, row0_o, row1_o and row2_o are 0. col_o holds its last value.

## Timing
- Reset values: vsync_o=0, de_o=0, row0_o=0, row1_o=0, row2_o=0, col_o=0. Internal state also resets: col=0, lines_seen=0, de_d=0, vsync_d=0.
- Latency: exactly 1 cycle from input to every output. All outputs for one pixel are aligned on the same cycle.
- Throughput: one pixel per clock. No backpressure.
- Horizontal blanking must be >=1 cycle between lines. This lets the delayed ram2 write of the last column retire.
- The ram2 write address always trails the read address by 1. No same-address read/write conflict occurs within a line.
- vsync_i rising mid-line: lines_seen clears for pixels from the next cycle on. Rows 1 and 2 are zero from that point.
- Reset mid-frame: all state clears immediately, asynchronously. The first two lines after release output zero-padded rows 1 and 2.
- Lines shorter than H_ACT: unwritten columns keep stale data from older lines. This is acceptable, because downstream uses only columns inside the active width.

## Test plan
- Reset: hold rstn=0 with random inputs. All outputs must be 0. Release rstn; the first output appears 1 cycle after the first de_i.
- Basic window, H_ACT=8, DW=8:
  - Stimulus: vsync pulse, then 3 lines with pixel = 16*line+col and blanking of 4 cycles.
  - Line 0: row1=row2=0.
  - Line 1: row1 = col, row2 = 0.
  - Line 2: row1 = 16+col, row2 = col.
  - col_o runs 0..7 on every line.
- Frame restart: send 3 lines, then a vsync_i rise, then 1 line. The new line must have row1=row2=0, even though the RAMs hold data.
- Overlong line: H_ACT=8, a 10-pixel line.
  - col_o saturates at 8.
  - Pixels 8 and 9 show row1=row2=0.
  - The next line's row1 at columns 0..7 is correct, with no corruption from pixels 8 and 9.
- Minimum blanking: 1-cycle gaps between 4 lines. row2 on line 3 must equal line 1 data at every column, including column H_ACT-1.
- Mid-line reset: assert rstn low at column 3 of line 2 and release it while de_i is still high.
  - col restarts at 0.
  - That line and the next show row2=0.
  - The line after those two shows full window data.
